// File: rtl/r8051_uart_pkg.sv
// Shared constants and state types for the 8051-style serial port.
package r8051_pkg;

    localparam logic [7:0] SCON_ADDR = 8'h98;
    localparam logic [7:0] SBUF_ADDR = 8'h99;

    // SCON bit positions
    localparam int SCON_RI  = 0;
    localparam int SCON_TI  = 1;
    localparam int SCON_RB8 = 2;
    localparam int SCON_TB8 = 3;
    localparam int SCON_REN = 4;
    localparam int SCON_SM2 = 5;
    localparam int SCON_SM1 = 6;
    localparam int SCON_SM0 = 7;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/r8051_uart_if.sv
// CPU SFR bus as seen by the serial port: read strobe/address/data and write strobe/address/data.
interface r8051_uart_if;
    logic        ram_rd_en_sfr;
    logic [15:0] ram_rd_addr;
    logic [7:0]  ram_rd_byte;
    logic        ram_rd_hit;
    logic        ram_wr_en_sfr;
    logic [15:0] ram_wr_addr;
    logic [7:0]  ram_wr_byte;

    modport master (
        output ram_rd_en_sfr, ram_rd_addr, ram_wr_en_sfr, ram_wr_addr, ram_wr_byte,
        input  ram_rd_byte, ram_rd_hit
    );

    modport slave (
        input  ram_rd_en_sfr, ram_rd_addr, ram_wr_en_sfr, ram_wr_addr, ram_wr_byte,
        output ram_rd_byte, ram_rd_hit
    );
endinterface

// File: rtl/r8051_uart_rx.sv
// Receiver: 2-flop synchronizer, start-edge detect, mid-bit sampler and RX FSM.
//
// state    | meaning
// RX_IDLE  | waiting for a synchronized falling edge with REN=1
// RX_START | timing the start bit; a high mid-bit sample rejects it as a glitch
// RX_DATA  | sampling 8 data bits LSB first
// RX_STOP  | waiting for the stop-bit sample, then back to idle at once
module r8051_uart_rx
    import r8051_pkg::*;
#(
    parameter int BAUD_DIV = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rxd,
    input  logic       i_ren,
    input  logic       i_ri,
    output logic       o_load,
    output logic [7:0] o_data,
    output logic       o_rb8
);
    localparam logic [15:0] LP_DIV_M1 = 16'(BAUD_DIV - 1);
    localparam logic [15:0] LP_HALF   = 16'(BAUD_DIV / 2);

    logic        r_sync1;
    logic        r_sync2;
    logic        r_sync_prev;
    rx_state_t   r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;

    logic w_fall;
    logic w_sample;
    logic w_bit_end;

    assign w_fall    = r_sync_prev & ~r_sync2;
    assign w_sample  = (r_cnt == LP_HALF);
    assign w_bit_end = (r_cnt == LP_DIV_M1);

    // Frame complete: stop-bit sample point, receiver still enabled, RI free.
    assign o_load = (r_state == RX_STOP) && w_sample && i_ren && !i_ri;
    assign o_data = r_shift;
    assign o_rb8  = r_sync2;

    // Synchronizer plus one extra stage for falling-edge detection; all idle high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_sync_prev <= 1'b1;
        end else begin
            r_sync1     <= i_rxd;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
        end
    end

    // RX FSM with per-bit counter; clearing REN aborts to idle from any state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RX_IDLE;
            r_cnt   <= 16'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
        end else if (!i_ren) begin
            r_state <= RX_IDLE;
            r_cnt   <= 16'd0;
            r_bit   <= 3'd0;
        end else begin
            case (r_state)
                RX_IDLE: begin
                    r_cnt <= 16'd0;
                    if (w_fall) begin
                        r_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (w_sample && r_sync2) begin
                        r_state <= RX_IDLE;
                        r_cnt   <= 16'd0;
                    end else if (w_bit_end) begin
                        r_state <= RX_DATA;
                        r_cnt   <= 16'd0;
                        r_bit   <= 3'd0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (w_sample) begin
                        r_shift <= {r_sync2, r_shift[7:1]};
                    end
                    if (w_bit_end) begin
                        r_cnt <= 16'd0;
                        if (r_bit == 3'd7) begin
                            r_state <= RX_STOP;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (w_sample) begin
                        r_state <= RX_IDLE;
                        r_cnt   <= 16'd0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= RX_IDLE;
                    r_cnt   <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/r8051_uart.sv
// 8051 mode-1 serial port: SCON/SBUF SFRs, transmitter and receiver instance.
//
// state    | meaning
// TX_IDLE  | txd high, waiting for an SBUF write
// TX_START | driving the start bit (0)
// TX_DATA  | shifting 8 data bits LSB first
// TX_STOP  | driving the stop bit (1); TI set on its last cycle
module r8051_uart
    import r8051_pkg::*;
#(
    parameter int BAUD_DIV = 868
) (
    input  logic        clk,
    input  logic        rst,
    r8051_uart_if.slave bus,
    input  logic        uart_rxd,
    output logic        uart_txd,
    output logic        uart_irq
);
    localparam logic [15:0] LP_DIV_M1 = 16'(BAUD_DIV - 1);

    logic [7:0]  r_scon;
    logic [7:0]  r_sbuf_rx;
    logic [7:0]  r_tx_shift;
    logic [7:0]  r_rd_byte;
    logic        r_rd_hit;
    logic        r_txd;
    logic        r_irq;
    tx_state_t   r_tx_state;
    logic [15:0] r_tx_cnt;
    logic [2:0]  r_tx_bit;

    logic       w_scon_wr;
    logic       w_sbuf_wr;
    logic       w_scon_rd;
    logic       w_sbuf_rd;
    logic       w_tx_cnt_end;
    logic       w_tx_done;
    logic       w_rx_load;
    logic       w_rx_rb8;
    logic [7:0] w_rx_data;
    logic [7:0] w_scon_next;
    logic       w_unused_addr_hi;

    assign w_scon_wr    = bus.ram_wr_en_sfr && (bus.ram_wr_addr[7:0] == SCON_ADDR);
    assign w_sbuf_wr    = bus.ram_wr_en_sfr && (bus.ram_wr_addr[7:0] == SBUF_ADDR);
    assign w_scon_rd    = (bus.ram_rd_addr[7:0] == SCON_ADDR);
    assign w_sbuf_rd    = (bus.ram_rd_addr[7:0] == SBUF_ADDR);
    assign w_tx_cnt_end = (r_tx_cnt == LP_DIV_M1);
    assign w_tx_done    = (r_tx_state == TX_STOP) && w_tx_cnt_end;

    // Only the low address byte selects an SFR.
    assign w_unused_addr_hi = ^{bus.ram_rd_addr[15:8], bus.ram_wr_addr[15:8]};

    assign bus.ram_rd_byte = r_rd_byte;
    assign bus.ram_rd_hit  = r_rd_hit;
    assign uart_txd        = r_txd;
    assign uart_irq        = r_irq;

    r8051_uart_rx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_rx (
        .clk    (clk),
        .rst    (rst),
        .i_rxd  (uart_rxd),
        .i_ren  (r_scon[SCON_REN]),
        .i_ri   (r_scon[SCON_RI]),
        .o_load (w_rx_load),
        .o_data (w_rx_data),
        .o_rb8  (w_rx_rb8)
    );

    // Next SCON: CPU write first, hardware flag sets layered on top so they win.
    always_comb begin
        w_scon_next = r_scon;
        if (w_scon_wr) begin
            w_scon_next = bus.ram_wr_byte;
        end
        if (w_tx_done) begin
            w_scon_next[SCON_TI] = 1'b1;
        end
        if (w_rx_load) begin
            w_scon_next[SCON_RI]  = 1'b1;
            w_scon_next[SCON_RB8] = w_rx_rb8;
        end
    end

    // SCON, receive holding register and interrupt; irq tracks the flags in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scon    <= 8'h00;
            r_sbuf_rx <= 8'h00;
            r_irq     <= 1'b0;
        end else begin
            r_scon <= w_scon_next;
            r_irq  <= w_scon_next[SCON_TI] | w_scon_next[SCON_RI];
            if (w_rx_load) begin
                r_sbuf_rx <= w_rx_data;
            end
        end
    end

    // Registered SFR read port; data holds between strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_byte <= 8'h00;
            r_rd_hit  <= 1'b0;
        end else if (bus.ram_rd_en_sfr) begin
            if (w_scon_rd) begin
                r_rd_byte <= r_scon;
                r_rd_hit  <= 1'b1;
            end else if (w_sbuf_rd) begin
                r_rd_byte <= r_sbuf_rx;
                r_rd_hit  <= 1'b1;
            end else begin
                r_rd_byte <= 8'h00;
                r_rd_hit  <= 1'b0;
            end
        end
    end

    // TX FSM; txd is registered alongside the state so it moves with each transition.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= 16'd0;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'h00;
            r_txd      <= 1'b1;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    r_tx_cnt <= 16'd0;
                    r_txd    <= 1'b1;
                    if (w_sbuf_wr) begin
                        r_tx_state <= TX_START;
                        r_tx_shift <= bus.ram_wr_byte;
                        r_txd      <= 1'b0;
                    end
                end
                TX_START: begin
                    if (w_tx_cnt_end) begin
                        r_tx_state <= TX_DATA;
                        r_tx_cnt   <= 16'd0;
                        r_tx_bit   <= 3'd0;
                        r_txd      <= r_tx_shift[0];
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 16'd1;
                    end
                end
                TX_DATA: begin
                    if (w_tx_cnt_end) begin
                        r_tx_cnt <= 16'd0;
                        if (r_tx_bit == 3'd7) begin
                            r_tx_state <= TX_STOP;
                            r_txd      <= 1'b1;
                        end else begin
                            r_tx_bit   <= r_tx_bit + 3'd1;
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            r_txd      <= r_tx_shift[1];
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 16'd1;
                    end
                end
                TX_STOP: begin
                    if (w_tx_cnt_end) begin
                        r_tx_state <= TX_IDLE;
                        r_tx_cnt   <= 16'd0;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 16'd1;
                    end
                end
                default: begin
                    r_tx_state <= TX_IDLE;
                    r_tx_cnt   <= 16'd0;
                    r_txd      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_r8051_uart.sv
// Bench for r8051_uart at BAUD_DIV=4: SFR vector table, directed frame sequences,
// and randomized TX/RX frames checked against a flag/buffer model kept here.
module tb_r8051_uart;

    localparam int BD = 4;

    logic clk;
    logic rst;
    logic uart_rxd;
    logic uart_txd;
    logic uart_irq;

    int n_tests;
    int n_fail;

    // Reference model of the CPU-visible state
    logic [7:0] m_scon;
    logic [7:0] m_sbuf;

    typedef struct {
        logic        is_wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_byte;
        logic        exp_hit;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[12];

    r8051_uart_if bus ();

    r8051_uart #(
        .BAUD_DIV (BD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .uart_rxd (uart_rxd),
        .uart_txd (uart_txd),
        .uart_irq (uart_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [39:0] act, input logic [39:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic sfr_write(input logic [15:0] addr, input logic [7:0] data);
        bus.ram_wr_en_sfr = 1'b1;
        bus.ram_wr_addr   = addr;
        bus.ram_wr_byte   = data;
        tick();
        bus.ram_wr_en_sfr = 1'b0;
    endtask

    task automatic sfr_read(input logic [15:0] addr, output logic [7:0] b, output logic h);
        bus.ram_rd_en_sfr = 1'b1;
        bus.ram_rd_addr   = addr;
        tick();
        b = bus.ram_rd_byte;
        h = bus.ram_rd_hit;
        bus.ram_rd_en_sfr = 1'b0;
    endtask

    task automatic read_check(input string nm, input logic [15:0] addr, input logic [7:0] exp_b,
                              input logic exp_h);
        logic [7:0] b;
        logic       h;
        sfr_read(addr, b, h);
        check({nm, "_byte"}, 40'(b), 40'(exp_b));
        check({nm, "_hit"}, 40'(h), 40'(exp_h));
    endtask

    // Expected txd waveform, one entry per clock: start 0, data LSB first, stop 1.
    function automatic logic [39:0] tx_wave(input logic [7:0] d);
        logic [9:0]  frame;
        logic [39:0] w;
        frame = {1'b1, d, 1'b0};
        for (int i = 0; i < 40; i++) w[i] = frame[i / BD];
        return w;
    endfunction

    // Send a byte on SBUF and record txd/irq for the 40 frame cycles; optional
    // second SBUF write 10 cycles into the frame.
    task automatic tx_frame(input string nm, input logic [7:0] d, input logic inj,
                            input logic [7:0] d2);
        logic [39:0] txv;
        logic [39:0] irqv;
        sfr_write(16'h0099, d);
        for (int i = 0; i < 40; i++) begin
            txv[i]  = uart_txd;
            irqv[i] = uart_irq;
            if (inj && i == 10) begin
                bus.ram_wr_en_sfr = 1'b1;
                bus.ram_wr_addr   = 16'h0099;
                bus.ram_wr_byte   = d2;
            end
            tick();
            bus.ram_wr_en_sfr = 1'b0;
        end
        m_scon[1] = 1'b1;
        check({nm, "_txd"}, txv, tx_wave(d));
        check({nm, "_irq_early"}, irqv, 40'd0);
        check({nm, "_irq"}, 40'(uart_irq), 40'd1);
    endtask

    // Drive one frame on rxd and apply the receive rules to the model.
    task automatic rx_frame(input logic [7:0] d);
        logic [9:0] frame;
        frame = {1'b1, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rxd = frame[i];
            repeat (BD) tick();
        end
        uart_rxd = 1'b1;
        repeat (3) tick();
        if (m_scon[4] && !m_scon[0]) begin
            m_sbuf    = d;
            m_scon[2] = 1'b1;
            m_scon[0] = 1'b1;
        end
    endtask

    initial begin
        logic [7:0] b;
        logic       h;
        logic [7:0] rnd;
        n_tests = 0;
        n_fail  = 0;
        m_scon  = 8'h00;
        m_sbuf  = 8'h00;

        vecs[0]  = '{1'b0, 16'h0098, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 16'h0098, 8'hE9, 8'h00, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 16'h0098, 8'h00, 8'hE9, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 16'h0090, 8'h00, 8'h00, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 16'h1298, 8'h00, 8'hE9, 1'b1, 1'b1};
        vecs[5]  = '{1'b1, 16'h0097, 8'hFF, 8'h00, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 16'h0098, 8'h00, 8'hE9, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 16'h0198, 8'h0A, 8'h00, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 16'h0098, 8'h00, 8'h0A, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 16'h0098, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 16'h0099, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 16'h00FF, 8'h00, 8'h00, 1'b0, 1'b0};

        rst               = 1'b0;
        uart_rxd          = 1'b1;
        bus.ram_rd_en_sfr = 1'b0;
        bus.ram_rd_addr   = 16'h0000;
        bus.ram_wr_en_sfr = 1'b0;
        bus.ram_wr_addr   = 16'h0000;
        bus.ram_wr_byte   = 8'h00;
        tick();
        tick();
        check("rst_txd", 40'(uart_txd), 40'd1);
        check("rst_irq", 40'(uart_irq), 40'd0);
        check("rst_rd_byte", 40'(bus.ram_rd_byte), 40'd0);
        check("rst_rd_hit", 40'(bus.ram_rd_hit), 40'd0);
        rst = 1'b1;
        tick();

        // SFR decode / read latency table
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].is_wr) begin
                sfr_write(vecs[i].addr, vecs[i].wdata);
            end else begin
                sfr_read(vecs[i].addr, b, h);
                check($sformatf("vec%0d_byte", i), 40'(b), 40'(vecs[i].exp_byte));
                check($sformatf("vec%0d_hit", i), 40'(h), 40'(vecs[i].exp_hit));
            end
            check($sformatf("vec%0d_irq", i), 40'(uart_irq), 40'(vecs[i].exp_irq));
        end

        // Read data holds without a strobe
        sfr_write(16'h0098, 8'hA0);
        read_check("hold_setup", 16'h0098, 8'hA0, 1'b1);
        bus.ram_rd_addr = 16'h0090;
        repeat (3) tick();
        check("hold_byte", 40'(bus.ram_rd_byte), 40'hA0);
        check("hold_hit", 40'(bus.ram_rd_hit), 40'd1);
        sfr_write(16'h0098, 8'h00);
        m_scon = 8'h00;

        // Single frame 0x55, TI after 40 cycles
        tx_frame("tx55", 8'h55, 1'b0, 8'h00);
        read_check("tx55_scon", 16'h0098, 8'h02, 1'b1);
        sfr_write(16'h0098, 8'h00);
        m_scon = 8'h00;

        // Second SBUF write mid-frame is dropped
        tx_frame("txdrop", 8'hA5, 1'b1, 8'hFF);
        read_check("txdrop_scon", 16'h0098, 8'h02, 1'b1);
        n_tests++;
        for (int i = 0; i < 12; i++) begin
            if (uart_txd !== 1'b1) begin
                n_fail++;
                $display("FAIL txdrop_idle: got txd=%0b at cycle %0d required 1", uart_txd, i);
                break;
            end
            tick();
        end
        sfr_write(16'h0098, 8'h00);
        m_scon = 8'h00;

        // Receive 0xA3 with REN set
        sfr_write(16'h0098, 8'h10);
        m_scon = 8'h10;
        rx_frame(8'hA3);
        check("rxA3_irq", 40'(uart_irq), 40'd1);
        read_check("rxA3_scon", 16'h0098, m_scon, 1'b1);
        read_check("rxA3_sbuf", 16'h0099, 8'hA3, 1'b1);

        // RI still set (RB8 cleared by CPU) -> second frame discarded
        sfr_write(16'h0098, 8'h11);
        m_scon = 8'h11;
        rx_frame(8'h3C);
        read_check("rxdisc_sbuf", 16'h0099, 8'hA3, 1'b1);
        read_check("rxdisc_scon", 16'h0098, 8'h11, 1'b1);

        // One-cycle glitch is rejected, then the receiver takes the next frame
        sfr_write(16'h0098, 8'h10);
        m_scon = 8'h10;
        uart_rxd = 1'b0;
        tick();
        uart_rxd = 1'b1;
        repeat (8) tick();
        check("glitch_irq", 40'(uart_irq), 40'd0);
        read_check("glitch_scon", 16'h0098, 8'h10, 1'b1);
        rx_frame(8'h5A);
        read_check("postglitch_scon", 16'h0098, m_scon, 1'b1);
        read_check("postglitch_sbuf", 16'h0099, m_sbuf, 1'b1);

        // SCON write landing on the cycle TI sets: TI survives
        sfr_write(16'h0098, 8'h00);
        m_scon = 8'h00;
        sfr_write(16'h0099, 8'h81);
        repeat (39) tick();
        check("race_pre_irq", 40'(uart_irq), 40'd0);
        sfr_write(16'h0098, 8'h10);
        m_scon = 8'h12;
        read_check("race_scon", 16'h0098, 8'h12, 1'b1);

        // Randomized frames against the model
        for (int k = 0; k < 5; k++) begin
            rnd = 8'($urandom_range(0, 255));
            sfr_write(16'h0098, 8'h00);
            m_scon = 8'h00;
            tx_frame($sformatf("rtx%0d", k), rnd, 1'($urandom_range(0, 1)), 8'($urandom));
            read_check($sformatf("rtx%0d_scon", k), 16'h0098, m_scon, 1'b1);
        end
        sfr_write(16'h0098, 8'h10);
        m_scon = 8'h10;
        for (int k = 0; k < 6; k++) begin
            rnd = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 2) != 0) begin
                sfr_write(16'h0098, m_scon & 8'hFE);
                m_scon = m_scon & 8'hFE;
            end
            rx_frame(rnd);
            read_check($sformatf("rrx%0d_scon", k), 16'h0098, m_scon, 1'b1);
            read_check($sformatf("rrx%0d_sbuf", k), 16'h0099, m_sbuf, 1'b1);
        end

        // Reset asserted during the start bit of a frame
        sfr_write(16'h0098, 8'h03);
        read_check("prerst_scon", 16'h0098, 8'h03, 1'b1);
        sfr_write(16'h0099, 8'hC3);
        tick();
        check("prerst_txd", 40'(uart_txd), 40'd0);
        check("prerst_irq", 40'(uart_irq), 40'd1);
        rst = 1'b0;
        #1;
        check("midrst_txd", 40'(uart_txd), 40'd1);
        check("midrst_irq", 40'(uart_irq), 40'd0);
        check("midrst_rd_byte", 40'(bus.ram_rd_byte), 40'd0);
        check("midrst_rd_hit", 40'(bus.ram_rd_hit), 40'd0);
        tick();
        tick();
        rst = 1'b1;
        m_scon = 8'h00;
        m_sbuf = 8'h00;
        tick();
        read_check("postrst_90", 16'h0090, 8'h00, 1'b0);
        read_check("postrst_scon", 16'h0098, 8'h00, 1'b1);
        read_check("postrst_sbuf", 16'h0099, 8'h00, 1'b1);
        n_tests++;
        for (int i = 0; i < 44; i++) begin
            if (uart_txd !== 1'b1) begin
                n_fail++;
                $display("FAIL postrst_txd_idle: got txd=%0b at cycle %0d required 1", uart_txd, i);
                break;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
